// File: rtl/dcache_req_arbiter.sv
// Two-port arbiter for the single DCache request port: MEM1 pipeline (port 0, priority) and
// store-buffer drain (port 1, anti-starvation). Optional perf counters under DCACHE_ARB_PERF_EN.
module dcache_req_arbiter #(
    parameter  int ADDR_W     = 32,
    parameter  int DATA_W     = 32,
    parameter  int STARVE_MAX = 4,
    localparam int SEL_W      = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic              req0_we,
    input  logic [SEL_W-1:0]  req0_sel,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic [2:0]        req0_type,
    output logic              req0_gnt,
    output logic              req0_ack,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic              req1_we,
    input  logic [SEL_W-1:0]  req1_sel,
    input  logic [DATA_W-1:0] req1_wdata,
    input  logic [2:0]        req1_type,
    output logic              req1_gnt,
    output logic              req1_ack,
    output logic              dcache_ce_o,
    output logic [ADDR_W-1:0] dcache_addr_o,
    output logic              dcache_we_o,
    output logic [SEL_W-1:0]  dcache_sel_o,
    output logic [DATA_W-1:0] dcache_data_o,
    output logic [2:0]        dcache_rd_type_o,
    output logic [2:0]        dcache_wr_type_o,
    input  logic              dcache_ready_i,
    input  logic              dcache_ack_i
`ifdef DCACHE_ARB_PERF_EN
    ,
    output logic [31:0]       perf_gnt0_o,
    output logic [31:0]       perf_gnt1_o,
    output logic [31:0]       perf_conflict_o
`endif
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t            state, state_nxt;
    logic              owner;
    logic              drop;
    logic [3:0]        starve_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [SEL_W-1:0]  sel_q;
    logic [DATA_W-1:0] data_q;
    logic [2:0]        type_q;

    logic eff_req0, grant, win1, ack_hit;

    assign eff_req0 = req0_valid & ~flush;
    // Gated by rst_n so no grant can escape while reset is held with requests pending.
    assign grant    = rst_n & (state == IDLE) & dcache_ready_i & (eff_req0 | req1_valid);
    assign win1     = req1_valid & ((starve_cnt == STARVE_LIM) | ~eff_req0);
    assign ack_hit  = (state == WAIT) & dcache_ack_i;

    assign req0_gnt = grant & ~win1;
    assign req1_gnt = grant & win1;
    // A flushed port-0 transaction still drains DCache, but its owner never sees the ack.
    assign req0_ack = ack_hit & ~owner & ~drop & ~flush;
    assign req1_ack = ack_hit & owner;

    assign dcache_ce_o      = (state == ISSUE);
    assign dcache_addr_o    = addr_q;
    assign dcache_we_o      = we_q;
    assign dcache_sel_o     = sel_q;
    assign dcache_data_o    = data_q;
    assign dcache_rd_type_o = we_q ? 3'b000 : type_q;
    assign dcache_wr_type_o = we_q ? type_q : 3'b000;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (dcache_ack_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= 1'b0;
            drop       <= 1'b0;
            starve_cnt <= 4'd0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            sel_q      <= '0;
            data_q     <= '0;
            type_q     <= 3'b000;
        end else begin
            state <= state_nxt;
            if (grant) begin
                owner  <= win1;
                addr_q <= win1 ? req1_addr  : req0_addr;
                we_q   <= win1 ? req1_we    : req0_we;
                sel_q  <= win1 ? req1_sel   : req0_sel;
                data_q <= win1 ? req1_wdata : req0_wdata;
                type_q <= win1 ? req1_type  : req0_type;
                if (win1)
                    starve_cnt <= 4'd0;
                else if (req1_valid && starve_cnt != STARVE_LIM)
                    starve_cnt <= starve_cnt + 4'd1;
            end
            if (ack_hit)
                drop <= 1'b0;
            else if (state != IDLE && !owner && flush)
                drop <= 1'b1;
        end
    end

`ifdef DCACHE_ARB_PERF_EN
    logic [31:0] perf_gnt0, perf_gnt1, perf_conflict;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_gnt0     <= '0;
            perf_gnt1     <= '0;
            perf_conflict <= '0;
        end else begin
            if (req0_gnt) perf_gnt0 <= perf_gnt0 + 32'd1;
            if (req1_gnt) perf_gnt1 <= perf_gnt1 + 32'd1;
            if (state == IDLE && eff_req0 && req1_valid) perf_conflict <= perf_conflict + 32'd1;
        end
    end

    assign perf_gnt0_o     = perf_gnt0;
    assign perf_gnt1_o     = perf_gnt1;
    assign perf_conflict_o = perf_conflict;
`endif

endmodule
